gemm_sched: RTL and testbench
=============================

# gemm_sched

Sequencer for the GEMM functional unit's 4x4 systolic tile datapath. Accepts one GEMM instruction at a time (D = A·B + C, register tiles rs1/rs2/rs3/rd) and walks the array through weight load, input streaming and result drain. It tracks which weight tile is resident in the array and skips reloading it when consecutive instructions share rs2. It sits between issue and the array/register-file ports, and honours pipeline flush and freeze.

## Interface
- DIM, 4, tile rows per phase; row counters are $clog2(DIM) bits.
- REG_W, 4, register index width.
- CLK  in  1  clock.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- fetch_p  in  32  instruction; rs1=[10:7], rs2=[14:11], rs3=[18:15], rd=[22:19].
- instr_valid  in  1  fetch_p holds a GEMM instruction.
- instr_ready  out  1  block is in IDLE, not frozen and not flushing.
- flush  in  1  abort the current instruction and drop the weight tag.
- freeze  in  1  stall all progress.
- inv_valid, inv_reg  in  1, REG_W  an external writer updated register inv_reg.
- rf_rd_en  out  1  register-file tile-row read strobe.
- rf_rd_reg, rf_rd_row  out  REG_W, 2  register and row being read.
- rf_c_reg  out  REG_W  accumulator tile (rs3), same row as rf_rd_row while streaming.
- sa_wload  out  1  array latches the weight row on the read data.
- sa_in_valid  out  1  array consumes the A/C row.
- sa_freeze  out  1  equals freeze.
- sa_clear  out  1  one-cycle pulse on flush.
- sa_out_valid  in  1  array presents one D result row.
- wb_en, wb_reg, wb_row  out  1, REG_W, 2  result-row writeback.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the instruction retires.
- wt_hit  out  1  one-cycle pulse when accept skips LOAD_W.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: on instr_valid & instr_ready, latch rs1/rs2/rs3/rd and clear both counters.
  - If wtag_valid && rs2 == wtag, go to STREAM and pulse wt_hit.
  - Otherwise go to LOAD_W.
- LOAD_W: rf_rd_en=1, rf_rd_reg=rs2, rf_rd_row=in_cnt, sa_wload=1.
  - in_cnt increments each cycle.
  - At in_cnt==DIM-1: set wtag=rs2 and wtag_valid=1, clear in_cnt, go to STREAM.
- STREAM: rf_rd_en=1, rf_rd_reg=rs1, rf_c_reg=rs3, rf_rd_row=in_cnt, sa_in_valid=1.
  - At in_cnt==DIM-1, go to DRAIN.
- Output counting runs in STREAM and DRAIN. Each sa_out_valid gives wb_en=1, wb_reg=rd, wb_row=out_cnt, then out_cnt++.
  - When the DIM-th row is written: done pulses next cycle and the state returns to IDLE.
  - sa_out_valid in IDLE or LOAD_W is ignored.
- Weight tag invalidation:
  - inv_valid && inv_reg==wtag clears wtag_valid.
  - Retiring with rd==wtag clears wtag_valid.
  - If invalidation coincides with the tag set at the end of LOAD_W, invalidation wins.
- freeze:
  - All state, counters and tag are held.
  - rf_rd_en, sa_wload, sa_in_valid, wb_en and instr_ready are forced to 0.
  - sa_out_valid is ignored.
- flush (has priority over freeze and over accept):
  - Next state is IDLE; counters and wtag_valid are cleared.
  - sa_clear pulses in the cycle flush is sampled.
  - No done pulse for the aborted instruction.
- Counters are DIM-modulo. No wrap occurs beyond DIM-1 because state changes at DIM-1.

## Timing
- Reset values (RST high at a clock edge):
  - state=IDLE, counters 0, wtag=0, wtag_valid=0.
  - All strobes, done, wt_hit and sa_clear are 0.
  - instr_ready=1 in the cycle after reset deasserts.
- RST mid-instruction behaves like flush, except sa_clear stays 0.
- Output timing:
  - Strobes and read addresses are Moore decodes of state and counters, gated only by freeze.
  - wb_* are combinational from sa_out_valid.
  - done and wt_hit are registered.
- Latency, accept at cycle T, unfrozen:
  - Miss: LOAD_W in T+1..T+4, STREAM in T+5..T+8.
  - Hit: STREAM in T+1..T+4.
  - done comes one cycle after the last result row.
  - A back-to-back accept is possible in the cycle done is high.

## Structure
- gemm_pkg holds:
  - gemm_state_t enum;
  - fetch_p field LSB/MSB constants (RS1_LSB=7, RS2_LSB=11, RS3_LSB=15, RD_LSB=19);
  - DIM default;
  - reg_idx_t typedef.
- gemm_wtag is one sub-module: tag register, valid bit, hit compare and invalidation priority. The FSM and counters stay in gemm_sched.

## Test plan
- Reset, then fetch_p with rs1=1, rs2=2, rs3=3, rd=4 -> LOAD_W rows 0-3 on reg 2, then STREAM rows 0-3 on reg 1 with rf_c_reg=3; four sa_out_valid -> wb rows 0-3 to reg 4, done once.
- Second instruction with rs2=2 -> wt_hit pulse, no sa_wload, STREAM starts the cycle after accept.
- inv_valid with inv_reg=2 between the two instructions -> no hit, LOAD_W repeats. Same test with inv_reg=5 -> hit.
- Freeze for 3 cycles at STREAM row 1 -> rf_rd_row holds at 1, strobes 0; resumes at row 1; total cycles extend by 3.
- Flush at LOAD_W row 2 while freeze is also high -> IDLE next cycle, sa_clear pulse, no done, next rs2=2 is a miss.
- Instruction with rd=2 equal to the resident tag 2 -> after done, a following rs2=2 is a miss.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and constants for the GEMM tile sequencer
package gemm_pkg;
    localparam int DIM_DEF   = 4;
    localparam int REG_W_DEF = 4;
    localparam int RS1_LSB   = 7;
    localparam int RS2_LSB   = 11;
    localparam int RS3_LSB   = 15;
    localparam int RD_LSB    = 19;
    typedef logic [REG_W_DEF-1:0] reg_idx_t;
    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} gemm_state_t;
endpackage

// File: rtl/gemm_wtag.sv
// gemm_wtag: resident weight-tile tag with hit compare and invalidation
module gemm_wtag import gemm_pkg::*; #(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             freeze,
    input  logic             set,
    input  logic [REG_W-1:0] set_reg,
    input  logic [REG_W-1:0] qry_reg,
    input  logic             inv_valid,
    input  logic [REG_W-1:0] inv_reg,
    input  logic             retire,
    input  logic [REG_W-1:0] ret_reg,
    output logic             hit
);
    logic [REG_W-1:0] wtag, wtag_n;
    logic             valid, valid_n;

    assign hit = valid && qry_reg == wtag;

    // a fresh load replaces the tag; an invalidation of the resulting tag beats the load
    always_comb begin
        wtag_n  = set ? set_reg : wtag;
        valid_n = (set || valid) && !(inv_valid && inv_reg == wtag_n) && !(retire && ret_reg == wtag);
    end

    // tag register, dropped on flush and held while frozen
    always_ff @(posedge CLK) begin
        if (RST) begin
            wtag  <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!freeze) begin
            wtag  <= wtag_n;
            valid <= valid_n;
        end
    end
endmodule

// File: rtl/gemm_sched.sv
// gemm_sched: weight-load / stream / drain sequencer for the 4x4 systolic GEMM tile
module gemm_sched import gemm_pkg::*; #(
    parameter int DIM   = DIM_DEF,
    parameter int REG_W = REG_W_DEF,
    localparam int CW   = $clog2(DIM)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      fetch_p,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             flush,
    input  logic             freeze,
    input  logic             inv_valid,
    input  logic [REG_W-1:0] inv_reg,
    output logic             rf_rd_en,
    output logic [REG_W-1:0] rf_rd_reg,
    output logic [CW-1:0]    rf_rd_row,
    output logic [REG_W-1:0] rf_c_reg,
    output logic             sa_wload,
    output logic             sa_in_valid,
    output logic             sa_freeze,
    output logic             sa_clear,
    input  logic             sa_out_valid,
    output logic             wb_en,
    output logic [REG_W-1:0] wb_reg,
    output logic [CW-1:0]    wb_row,
    output logic             busy,
    output logic             done,
    output logic             wt_hit
);
    gemm_state_t      state, state_n;
    logic [CW-1:0]    in_cnt, in_n, out_cnt, out_n;
    logic [REG_W-1:0] rs1, rs2, rs3, rd;
    logic             done_q, hit_q, accept, in_last, last_wb, tag_hit;
    logic             unused_fetch;

    assign unused_fetch = ^{fetch_p[31:RD_LSB+REG_W], fetch_p[RS1_LSB-1:0]};

    assign instr_ready = state == IDLE && !freeze && !flush;
    assign accept      = instr_valid && instr_ready;
    assign in_last     = in_cnt == CW'(DIM - 1);
    assign rf_rd_en    = (state == LOAD_W || state == STREAM) && !freeze;
    assign rf_rd_reg   = state == LOAD_W ? rs2 : rs1;
    assign rf_rd_row   = in_cnt;
    assign rf_c_reg    = rs3;
    assign sa_wload    = state == LOAD_W && !freeze;
    assign sa_in_valid = state == STREAM && !freeze;
    assign sa_freeze   = freeze;
    assign sa_clear    = flush && !RST;
    assign wb_en       = sa_out_valid && !freeze && (state == STREAM || state == DRAIN);
    assign wb_reg      = rd;
    assign wb_row      = out_cnt;
    assign last_wb     = wb_en && out_cnt == CW'(DIM - 1);
    assign busy        = state != IDLE;
    assign done        = done_q;
    assign wt_hit      = hit_q;

    gemm_wtag #(.REG_W(REG_W)) u_wtag (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .freeze    (freeze),
        .set       (state == LOAD_W && in_last),
        .set_reg   (rs2),
        .qry_reg   (fetch_p[RS2_LSB +: REG_W]),
        .inv_valid (inv_valid),
        .inv_reg   (inv_reg),
        .retire    (last_wb && !flush),
        .ret_reg   (rd),
        .hit       (tag_hit)
    );

    // next state and row counters; the last result row retires from any phase
    always_comb begin
        state_n = state;
        in_n    = in_cnt;
        out_n   = wb_en ? CW'(out_cnt + 1'b1) : out_cnt;
        case (state)
            IDLE: if (accept) begin
                state_n = tag_hit ? STREAM : LOAD_W;
                in_n    = '0;
                out_n   = '0;
            end
            LOAD_W: begin
                in_n    = in_last ? '0 : CW'(in_cnt + 1'b1);
                state_n = in_last ? STREAM : LOAD_W;
            end
            STREAM: begin
                in_n    = in_last ? '0 : CW'(in_cnt + 1'b1);
                state_n = in_last ? DRAIN : STREAM;
            end
            default: ;
        endcase
        if (last_wb)
            state_n = IDLE;
    end

    // state and counters: flush aborts, freeze holds
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (!freeze) begin
            state   <= state_n;
            in_cnt  <= in_n;
            out_cnt <= out_n;
        end
    end

    // one-cycle retire and weight-hit pulses
    always_ff @(posedge CLK) begin
        done_q <= !RST && !flush && last_wb;
        hit_q  <= !RST && accept && tag_hit;
    end

    // operand fields captured at accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            rs1 <= '0;
            rs2 <= '0;
            rs3 <= '0;
            rd  <= '0;
        end else if (accept) begin
            rs1 <= fetch_p[RS1_LSB +: REG_W];
            rs2 <= fetch_p[RS2_LSB +: REG_W];
            rs3 <= fetch_p[RS3_LSB +: REG_W];
            rd  <= fetch_p[RD_LSB +: REG_W];
        end
    end
endmodule

// File: tb/tb_gemm_sched.sv
// tb_gemm_sched: directed stimulus with a queue-based behavioural model of the GEMM sequencer
module tb_gemm_sched;
    import gemm_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] fetch_p = '0;
    logic        instr_valid = 1'b0, flush = 1'b0, freeze = 1'b0, inv_valid = 1'b0;
    reg_idx_t    inv_reg = '0;
    logic        instr_ready, rf_rd_en, sa_wload, sa_in_valid, sa_freeze, sa_clear, sa_out_valid;
    logic        wb_en, busy, done, wt_hit;
    reg_idx_t    rf_rd_reg, rf_c_reg, wb_reg;
    logic [1:0]  rf_rd_row, wb_row;
    logic [2:0]  pipe = '0;
    int          checks = 0, failures = 0;

    gemm_sched dut (
        .CLK(CLK), .RST(RST), .fetch_p(fetch_p), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .flush(flush), .freeze(freeze), .inv_valid(inv_valid), .inv_reg(inv_reg),
        .rf_rd_en(rf_rd_en), .rf_rd_reg(rf_rd_reg), .rf_rd_row(rf_rd_row), .rf_c_reg(rf_c_reg),
        .sa_wload(sa_wload), .sa_in_valid(sa_in_valid), .sa_freeze(sa_freeze), .sa_clear(sa_clear),
        .sa_out_valid(sa_out_valid), .wb_en(wb_en), .wb_reg(wb_reg), .wb_row(wb_row),
        .busy(busy), .done(done), .wt_hit(wt_hit)
    );

    always #5 CLK = ~CLK;

    // array stand-in: each consumed input row yields a result row three unfrozen cycles later
    always @(posedge CLK) begin
        if (RST || flush) pipe <= '0;
        else if (!freeze) pipe <= {pipe[1:0], sa_in_valid};
    end
    assign sa_out_valid = pipe[2];

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] fld(input int s1, input int s2, input int s3, input int d);
        fld = '0;
        fld[10:7]  = 4'(s1);
        fld[14:11] = 4'(s2);
        fld[18:15] = 4'(s3);
        fld[22:19] = 4'(d);
    endfunction

    typedef struct packed {logic w; logic [3:0] r; logic [1:0] row;} op_t;
    op_t      q[$];
    logic     m_act = 0, m_done = 0, m_hit = 0, m_tv = 0;
    reg_idx_t m_tag = 0, m_rd = 0, m_rs3 = 0;
    int       m_wb = 0;

    // model: pending tile-row reads as a queue, results counted per instruction
    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            m_act = 0; m_done = 0; m_hit = 0; m_tv = 0; m_tag = 0; m_wb = 0;
        end else begin
            logic rdy, rd_en, strm, wb, acc, h;
            op_t  hd;
            hd    = q.size() > 0 ? q[0] : op_t'(0);
            rdy   = !m_act && !freeze && !flush;
            rd_en = m_act && q.size() > 0 && !freeze;
            strm  = m_act && (q.size() == 0 || !q[0].w);
            wb    = strm && sa_out_valid && !freeze;
            chk("instr_ready", instr_ready, rdy);
            chk("busy", busy, m_act);
            chk("rf_rd_en", rf_rd_en, rd_en);
            chk("sa_wload", sa_wload, rd_en && hd.w);
            chk("sa_in_valid", sa_in_valid, rd_en && !hd.w);
            if (rd_en) begin
                chk("rf_rd_reg", rf_rd_reg, hd.r);
                chk("rf_rd_row", rf_rd_row, hd.row);
                if (!hd.w) chk("rf_c_reg", rf_c_reg, m_rs3);
            end
            chk("wb_en", wb_en, wb);
            if (wb) begin
                chk("wb_reg", wb_reg, m_rd);
                chk("wb_row", wb_row, m_wb);
            end
            chk("done", done, m_done);
            chk("wt_hit", wt_hit, m_hit);
            chk("sa_clear", sa_clear, flush);
            chk("sa_freeze", sa_freeze, freeze);
            acc = instr_valid && rdy;
            h   = m_tv && fetch_p[14:11] == m_tag;
            m_done = 0;
            m_hit  = 0;
            if (flush) begin
                q.delete();
                m_act = 0;
                m_tv  = 0;
            end else if (!freeze) begin
                if (rd_en) begin
                    if (hd.w && hd.row == 2'd3) begin
                        m_tag = hd.r;
                        m_tv  = 1;
                    end
                    void'(q.pop_front());
                end
                if (wb) begin
                    m_wb++;
                    if (m_wb == 4) begin
                        m_done = 1;
                        m_act  = 0;
                        q.delete();
                        if (m_rd == m_tag) m_tv = 0;
                    end
                end
                if (inv_valid && inv_reg == m_tag) m_tv = 0;
                if (acc) begin
                    if (!h) for (int i = 0; i < 4; i++) q.push_back({1'b1, fetch_p[14:11], 2'(i)});
                    for (int i = 0; i < 4; i++) q.push_back({1'b0, fetch_p[10:7], 2'(i)});
                    m_rd  = fetch_p[22:19];
                    m_rs3 = fetch_p[18:15];
                    m_act = 1;
                    m_wb  = 0;
                    m_hit = h;
                end
            end
        end
    end

    // issue one instruction and count cycles from accept to done; optionally chain the next one into the done cycle
    task automatic issue(input logic [31:0] f, input logic [31:0] nxt, input bit chain, input bit pre,
                         input bit frz_en, output int lat, output int nw, output int nh);
        int  nwb, fleft;
        bit  got, used;
        lat = 0; nw = 0; nh = 0; nwb = 0; fleft = 0; got = 0; used = 0;
        if (!pre) begin
            @(posedge CLK); #1;
            fetch_p = f;
            instr_valid = 1'b1;
            for (int k = 0; k < 50; k++) begin
                @(negedge CLK);
                if (instr_ready) begin
                    got = 1;
                    break;
                end
            end
            if (!got) chk("accept_timeout", 0, 1);
        end
        got = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK); #1;
            instr_valid = chain && nwb == 4;
            if (chain && nwb == 4) fetch_p = nxt;
            freeze = fleft > 0;
            if (fleft > 0) fleft--;
            @(negedge CLK);
            lat++;
            nw  += int'(sa_wload);
            nh  += int'(wt_hit);
            nwb += int'(wb_en);
            if (freeze) begin
                chk("frz_row_hold", rf_rd_row, 1);
                chk("frz_no_strobe", sa_in_valid, 0);
            end
            if (frz_en && !used && sa_in_valid && rf_rd_row == 2'd0) begin
                fleft = 3;
                used  = 1;
            end
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int  lat, nw, nh;
        bit  seen;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        issue(fld(1, 2, 3, 4), 0, 0, 0, 0, lat, nw, nh);
        chk("miss_lat", lat, 12); chk("miss_wload", nw, 4); chk("miss_hit", nh, 0);

        issue(fld(5, 2, 6, 7), 0, 0, 0, 0, lat, nw, nh);
        chk("hit_lat", lat, 8); chk("hit_wload", nw, 0); chk("hit_pulse", nh, 1);

        @(posedge CLK); #1 inv_valid = 1'b1; inv_reg = 4'd2;
        @(posedge CLK); #1 inv_valid = 1'b0;
        issue(fld(1, 2, 3, 4), 0, 0, 0, 0, lat, nw, nh);
        chk("inv2_lat", lat, 12); chk("inv2_wload", nw, 4); chk("inv2_hit", nh, 0);

        @(posedge CLK); #1 inv_valid = 1'b1; inv_reg = 4'd5;
        @(posedge CLK); #1 inv_valid = 1'b0;
        issue(fld(1, 2, 3, 8), 0, 0, 0, 0, lat, nw, nh);
        chk("inv5_lat", lat, 8); chk("inv5_hit", nh, 1);

        issue(fld(1, 2, 3, 4), 0, 0, 0, 1, lat, nw, nh);
        chk("frz_lat", lat, 11); chk("frz_hit", nh, 1);

        @(posedge CLK); #1 fetch_p = fld(1, 9, 3, 4); instr_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (instr_ready) begin
                seen = 1;
                break;
            end
        end
        @(posedge CLK); #1 instr_valid = 1'b0;
        for (int k = 0; k < 20 && seen; k++) begin
            @(negedge CLK);
            if (sa_wload && rf_rd_row == 2'd1) break;
            @(posedge CLK); #1;
        end
        chk("flush_setup", int'(seen), 1);
        @(posedge CLK); #1 flush = 1'b1; freeze = 1'b1;
        @(negedge CLK);
        chk("flush_clear", sa_clear, 1);
        @(posedge CLK); #1 flush = 1'b0; freeze = 1'b0;
        @(negedge CLK);
        chk("flush_idle", busy, 0);
        chk("flush_nodone", done, 0);

        issue(fld(1, 2, 3, 4), 0, 0, 0, 0, lat, nw, nh);
        chk("postflush_lat", lat, 12); chk("postflush_wload", nw, 4); chk("postflush_hit", nh, 0);

        issue(fld(1, 2, 3, 2), fld(1, 2, 3, 4), 1, 0, 0, lat, nw, nh);
        chk("rd2_lat", lat, 8); chk("rd2_hit", nh, 1);
        chk("b2b_ready", instr_ready, 1);
        issue(fld(1, 2, 3, 4), 0, 0, 1, 0, lat, nw, nh);
        chk("rdinv_lat", lat, 12); chk("rdinv_wload", nw, 4); chk("rdinv_hit", nh, 0);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
